tt_sweeper: RTL

Synthesisable exhaustive-stimulus sequencer for small combinational units under test. Drives every N_IN-bit input combination in ascending binary or Gray order and holds each for HOLD cycles. On the last hold cycle of each vector it samples the unit's N_OUT-bit response and folds it into a 16-bit MISR signature, which it compares against a golden value. Sits between a combinational unit (e.g. a 3-in/3-out function block) and the lab board or a bench, replacing hand-written per-vector stimulus lists.

---
 rtl/tt_pkg.sv | 25 ++
 rtl/tt_sweeper_misr16.sv | 29 ++
 rtl/tt_sweeper.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared types, constants and helpers for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          SIG_W        = 16;
  localparam logic [15:0] SIG_POLY_DEF = 16'h8005;
  localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;

  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  // One MISR step: shift left, fold in the polynomial on carry-out, xor the response.
  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [15:0] din,
                                            input logic [15:0] poly);
    return {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/tt_sweeper_misr16.sv
// 16-bit multiple-input signature register; reseeds on init, folds din on en.
module misr16
  import tt_pkg::*;
#(
  parameter logic [15:0] POLY = SIG_POLY_DEF,
  parameter logic [15:0] SEED = SIG_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  // Signature register: init has priority over a fold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (init) begin
      sig <= SEED;
    end else if (en) begin
      sig <= misr_step(sig, din, POLY);
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive-stimulus sequencer: walks all 2^N_IN vectors, holds each HOLD
// cycles, folds the sampled response into a MISR and checks it against golden.
module tt_sweeper
  import tt_pkg::*;
#(
  parameter int          N_IN     = 3,
  parameter int          N_OUT    = 3,
  parameter int          HOLD     = 10,
  parameter int          GRAY     = 0,
  parameter logic [15:0] SIG_POLY = SIG_POLY_DEF,
  parameter logic [15:0] SIG_SEED = SIG_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       golden,
  input  logic [N_OUT-1:0]  dut_out,
  output logic [N_IN-1:0]   stim,
  output logic [N_IN-1:0]   vec_idx,
  output logic              sample,
  output logic              busy,
  output logic              done,
  output logic [15:0]       signature,
  output logic              pass
);

  localparam int              HCW          = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST    = HCW'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST     = '1;
  localparam logic            SAMPLE_FIRST = (HOLD == 1) ? 1'b1 : 1'b0;

  state_e           state_r;
  logic [HCW-1:0]   hold_cnt_r;
  logic [N_IN-1:0]  vec_idx_r;
  logic [N_IN-1:0]  stim_r;
  logic             sample_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  logic             start_ok_s;
  logic             abort_ok_s;
  logic [N_IN-1:0]  vec_next_s;
  logic [15:0]      sig_s;
  logic [15:0]      sig_next_s;

  function automatic logic [N_IN-1:0] to_stim(input logic [N_IN-1:0] v);
    if (GRAY != 0) begin
      return N_IN'(bin2gray(16'(v)));
    end else begin
      return v;
    end
  endfunction

  assign start_ok_s = start && (state_r != ST_RUN);
  assign abort_ok_s = abort && (state_r == ST_RUN);
  assign vec_next_s = vec_idx_r + N_IN'(1);
  // Signature the MISR will hold after this edge's fold, used to grade pass.
  assign sig_next_s = misr_step(sig_s, SIG_W'(dut_out), SIG_POLY);

  misr16 #(
    .POLY (SIG_POLY),
    .SEED (SIG_SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .init (start_ok_s),
    .en   (sample_r && !abort_ok_s),
    .din  (SIG_W'(dut_out)),
    .sig  (sig_s)
  );

  // Sequencer FSM with registered stimulus and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= '0;
      vec_idx_r  <= '0;
      stim_r     <= '0;
      sample_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r    <= ST_RUN;
            hold_cnt_r <= '0;
            vec_idx_r  <= '0;
            stim_r     <= to_stim('0);
            sample_r   <= SAMPLE_FIRST;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            vec_idx_r  <= '0;
            stim_r     <= '0;
            sample_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
          end else if (sample_r) begin
            hold_cnt_r <= '0;
            if (vec_idx_r == VEC_LAST) begin
              // Terminal vector: golden is graded only here.
              state_r  <= ST_DONE;
              stim_r   <= '0;
              sample_r <= 1'b0;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              pass_r   <= (sig_next_s == golden);
            end else begin
              vec_idx_r <= vec_next_s;
              stim_r    <= to_stim(vec_next_s);
              sample_r  <= SAMPLE_FIRST;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HCW'(1);
            sample_r   <= ((hold_cnt_r + HCW'(1)) == HOLD_LAST);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          hold_cnt_r <= '0;
          vec_idx_r  <= '0;
          stim_r     <= '0;
          sample_r   <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          pass_r     <= 1'b0;
        end
      endcase
    end
  end

  assign stim      = stim_r;
  assign vec_idx   = vec_idx_r;
  assign sample    = sample_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = sig_s;

endmodule
